// File: rtl/sample_fifo_ctrl.sv
// Sample FIFO controller: round-robin write arbiter and read sequencer that generate the
// strobe/release pulses for a FIFO that advances on strobe falling edges. Option: SAMPLE_FIFO_CTRL_DROP_EN.
module sample_fifo_ctrl #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DATA_W  = 8
) (
    input  logic                      sys_clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      fifo_write_en,
    output logic [DATA_W-1:0]         fifo_di,
    input  logic                      fifo_isFull,
    output logic                      fifo_read_en,
    input  logic [DATA_W-1:0]         fifo_d_out,
    input  logic                      fifo_isEmpty,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef SAMPLE_FIFO_CTRL_DROP_EN
    ,
    output logic [15:0]               drop_count
`endif
);

    localparam int unsigned PtrW = $clog2(NUM_REQ);

    localparam logic [1:0] W_IDLE    = 2'd0;
    localparam logic [1:0] W_STROBE  = 2'd1;
    localparam logic [1:0] W_GAP     = 2'd2;
`ifdef SAMPLE_FIFO_CTRL_DROP_EN
    localparam logic [1:0] W_DROP    = 2'd3;
`endif

    localparam logic [1:0] R_IDLE    = 2'd0;
    localparam logic [1:0] R_STROBE  = 2'd1;
    localparam logic [1:0] R_RELEASE = 2'd2;
    localparam logic [1:0] R_VALID   = 2'd3;

    logic [1:0]         w_state_q, w_state_d;
    logic [1:0]         r_state_q, r_state_d;
    logic [PtrW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               write_en_q, write_en_d;
    logic [DATA_W-1:0]  di_q, di_d;
    logic               read_en_q, read_en_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
`ifdef SAMPLE_FIFO_CTRL_DROP_EN
    logic [15:0]        drop_q, drop_d;
`endif

    logic [PtrW:0]      cand;
    logic               win_valid;
    logic [PtrW-1:0]    win_idx;
    logic [DATA_W-1:0]  win_data;

    // Scan rr_ptr+1, rr_ptr+2, ... with wrap; the first asserted request wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (PtrW + 1)'(i);
            if (cand >= (PtrW + 1)'(NUM_REQ)) begin
                cand = cand - (PtrW + 1)'(NUM_REQ);
            end
            if (!win_valid && req[cand[PtrW-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = cand[PtrW-1:0];
            end
        end
        win_data = req_data[win_idx*DATA_W +: DATA_W];
    end

    always_comb begin
        w_state_d  = w_state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = '0;
        write_en_d = 1'b0;
        di_d       = di_q;
`ifdef SAMPLE_FIFO_CTRL_DROP_EN
        drop_d     = drop_q;
`endif
        case (w_state_q)
            W_IDLE: begin
                if (win_valid && !fifo_isFull) begin
                    w_state_d  = W_STROBE;
                    rr_ptr_d   = win_idx;
                    grant_d    = NUM_REQ'(1) << win_idx;
                    write_en_d = 1'b1;
                    di_d       = win_data;
                end
`ifdef SAMPLE_FIFO_CTRL_DROP_EN
                else if (win_valid) begin
                    // Full: acknowledge the source so it moves on, but never strobe the FIFO.
                    w_state_d = W_DROP;
                    rr_ptr_d  = win_idx;
                    grant_d   = NUM_REQ'(1) << win_idx;
                    if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                end
`endif
            end
            W_STROBE: w_state_d = W_GAP;
            default:  w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d   = r_state_q;
        read_en_d   = 1'b0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (r_state_q)
            R_IDLE: begin
                if (!fifo_isEmpty && !out_valid_q) begin
                    r_state_d = R_STROBE;
                    read_en_d = 1'b1;
                end
            end
            R_STROBE: r_state_d = R_RELEASE;
            R_RELEASE: begin
                r_state_d   = R_VALID;
                out_data_d  = fifo_d_out;
                out_valid_d = 1'b1;
            end
            R_VALID: begin
                if (out_ready) begin
                    r_state_d   = R_IDLE;
                    out_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            rr_ptr_q    <= PtrW'(NUM_REQ - 1);
            grant_q     <= '0;
            write_en_q  <= 1'b0;
            di_q        <= '0;
            read_en_q   <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef SAMPLE_FIFO_CTRL_DROP_EN
            drop_q      <= '0;
`endif
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            write_en_q  <= write_en_d;
            di_q        <= di_d;
            read_en_q   <= read_en_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
`ifdef SAMPLE_FIFO_CTRL_DROP_EN
            drop_q      <= drop_d;
`endif
        end
    end

    assign grant         = grant_q;
    assign fifo_write_en = write_en_q;
    assign fifo_di       = di_q;
    assign fifo_read_en  = read_en_q;
    assign out_data      = out_data_q;
    assign out_valid     = out_valid_q;
`ifdef SAMPLE_FIFO_CTRL_DROP_EN
    assign drop_count    = drop_q;
`endif

endmodule

// File: tb/tb_sample_fifo_ctrl.sv
// Bench for sample_fifo_ctrl: edge-triggered FIFO model, round-robin reference and an
// output scoreboard popped by an independent monitor.
module tb_sample_fifo_ctrl;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned DEPTH   = 16;

    logic                      sys_clock = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic                      fifo_write_en;
    logic [DATA_W-1:0]         fifo_di;
    logic                      fifo_isFull;
    logic                      fifo_read_en;
    logic [DATA_W-1:0]         fifo_d_out;
    logic                      fifo_isEmpty;
    logic [DATA_W-1:0]         out_data;
    logic                      out_valid;
    logic                      out_ready;
`ifdef SAMPLE_FIFO_CTRL_DROP_EN
    logic [15:0]               drop_count;
`endif

    logic [DATA_W-1:0] src_data [NUM_REQ];

    always #5 sys_clock = ~sys_clock;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
        assign req_data[g*DATA_W +: DATA_W] = src_data[g];
    end

    sample_fifo_ctrl #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W)
    ) dut (
        .sys_clock     (sys_clock),
        .reset         (reset),
        .req           (req),
        .req_data      (req_data),
        .grant         (grant),
        .fifo_write_en (fifo_write_en),
        .fifo_di       (fifo_di),
        .fifo_isFull   (fifo_isFull),
        .fifo_read_en  (fifo_read_en),
        .fifo_d_out    (fifo_d_out),
        .fifo_isEmpty  (fifo_isEmpty),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
`ifdef SAMPLE_FIFO_CTRL_DROP_EN
        ,
        .drop_count    (drop_count)
`endif
    );

    // FIFO: 16 slots, 15 usable; pointers move on the falling edge of each strobe.
    logic [DATA_W-1:0] fmem [DEPTH];
    logic [3:0]        wptr, rptr;
    logic              we_prev, re_prev, full_seen;
    logic [DATA_W-1:0] d_out_q;

    assign fifo_isEmpty = (wptr == rptr);
    assign fifo_isFull  = ((wptr + 4'd1) == rptr);
    assign fifo_d_out   = d_out_q;

    always @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            we_prev   <= 1'b0;
            re_prev   <= 1'b0;
            full_seen <= 1'b0;
            d_out_q   <= '0;
        end else begin
            we_prev   <= fifo_write_en;
            re_prev   <= fifo_read_en;
            full_seen <= fifo_isFull;
            if (we_prev && !fifo_write_en) begin
                fmem[wptr] <= fifo_di;
                wptr       <= wptr + 4'd1;
            end
            if (fifo_read_en) d_out_q <= fmem[rptr];
            if (re_prev && !fifo_read_en) rptr <= rptr + 4'd1;
        end
    end

    logic [DATA_W-1:0]  exp_q [$];
    int                 n_pass;
    int                 n_total;
    int                 n_popped;
    int                 last_w;
    int                 step_no;
    int                 grants_seen;
    int                 drops_exp;
    int                 src_mode;   // 0: keep requesting, 1: random re-request, 2: drop after grant
    bit                 raise_en;
    bit                 ready_rand;
    logic [NUM_REQ-1:0] pend;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    endtask

    function automatic int predict(input logic [NUM_REQ-1:0] r, input int last);
        for (int i = 1; i <= NUM_REQ; i++) begin
            int c = (last + i) % NUM_REQ;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic step();
        logic [NUM_REQ-1:0] pend_old;
        int p;
        @(posedge sys_clock);
        #1;
        step_no++;
        pend_old = pend;
        pend     = '0;
        if (ready_rand) out_ready = ($urandom_range(3) != 0);
        if (grant != '0) begin
            grants_seen++;
            p = predict(req, last_w);
            if (p < 0) begin
                check("grant_without_req", 32'(grant), 32'(0));
            end else begin
                check("grant_rr", 32'(grant), 32'(1) << p);
                if (full_seen) begin
`ifdef SAMPLE_FIFO_CTRL_DROP_EN
                    if (drops_exp < 65535) drops_exp++;
`else
                    check("grant_while_full", 32'(grant), 32'(0));
`endif
                end else begin
                    exp_q.push_back(src_data[p]);
                end
                last_w  = p;
                pend[p] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pend_old[i]) begin
                if (src_mode == 1) begin
                    req[i]      = 1'($urandom_range(1));
                    src_data[i] = DATA_W'($urandom);
                end else if (src_mode == 2) begin
                    req[i] = 1'b0;
                end
            end
            if (raise_en && !req[i] && !pend[i] && $urandom_range(2) == 0) begin
                req[i]      = 1'b1;
                src_data[i] = DATA_W'($urandom);
            end
        end
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b1;
        #1;
        check({tag, "_grant"}, 32'(grant), 32'(0));
        check({tag, "_write_en"}, 32'(fifo_write_en), 32'(0));
        check({tag, "_di"}, 32'(fifo_di), 32'(0));
        check({tag, "_read_en"}, 32'(fifo_read_en), 32'(0));
        check({tag, "_out_data"}, 32'(out_data), 32'(0));
        check({tag, "_out_valid"}, 32'(out_valid), 32'(0));
`ifdef SAMPLE_FIFO_CTRL_DROP_EN
        check({tag, "_drop_count"}, 32'(drop_count), 32'(0));
`endif
        exp_q.delete();
        req       = '0;
        pend      = '0;
        last_w    = NUM_REQ - 1;
        drops_exp = 0;
        for (int i = 0; i < NUM_REQ; i++) src_data[i] = '0;
        repeat (2) @(posedge sys_clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_until_grant(input int budget, input string name);
        int g0 = grants_seen;
        int n  = 0;
        while (grants_seen == g0 && n < budget) begin
            step();
            n++;
        end
        check({name, "_grant_seen"}, 32'(grants_seen - g0), 32'(1));
    endtask

    task automatic wait_req_clear(input int budget, input string name);
        int n = 0;
        while (req != '0 && n < budget) begin
            step();
            n++;
        end
        check({name, "_req_cleared"}, 32'(req), 32'(0));
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < budget) begin
            step();
            n++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'(0));
    endtask

    // Monitor: pops the scoreboard on every accepted output and polices the hold rules.
    initial begin
        logic              prev_hold;
        logic [DATA_W-1:0] prev_data;
        logic [DATA_W-1:0] exp;
        prev_hold = 1'b0;
        prev_data = '0;
        n_popped  = 0;
        forever begin
            @(negedge sys_clock);
            if (reset) begin
                prev_hold = 1'b0;
            end else begin
                if (out_valid) check("read_en_while_valid", 32'(fifo_read_en), 32'(0));
                if (prev_hold) begin
                    check("out_valid_held", 32'(out_valid), 32'(1));
                    check("out_data_stable", 32'(out_data), 32'(prev_data));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL out_unexpected: got 0x%0h, expected no output", out_data);
                    end else begin
                        exp = exp_q.pop_front();
                        check("out_data", 32'(out_data), 32'(exp));
                        n_popped++;
                    end
                end
                prev_hold = out_valid && !out_ready;
                prev_data = out_data;
            end
        end
    end

    initial begin
        int g0;
        int d0;
        int n;
        int prev_gs;
        int base;
        bit first;
        logic [DATA_W-1:0] held;

        n_pass      = 0;
        n_total     = 0;
        step_no     = 0;
        grants_seen = 0;
        drops_exp   = 0;
        last_w      = NUM_REQ - 1;
        pend        = '0;
        src_mode    = 2;
        raise_en    = 1'b0;
        ready_rand  = 1'b0;
        reset       = 1'b0;
        req         = '0;
        out_ready   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) src_data[i] = '0;
        #2;
        apply_reset("por");

        // Single write then drain.
        src_data[0] = 8'hA5;
        req         = 2'b01;
        out_ready   = 1'b1;
        run_until_grant(4, "t1");
        check("t1_grant", 32'(grant), 32'(1));
        check("t1_write_en", 32'(fifo_write_en), 32'(1));
        check("t1_di", 32'(fifo_di), 32'hA5);
        step();
        check("t1_write_en_pulse", 32'(fifo_write_en), 32'(0));
        check("t1_grant_pulse", 32'(grant), 32'(0));
        check("t1_di_held", 32'(fifo_di), 32'hA5);
        drain(30, "t1");

        // Both sources held: grants alternate every 3 cycles.
        apply_reset("t2_pre");
        src_mode    = 0;
        src_data[0] = 8'h11;
        src_data[1] = 8'h22;
        req         = 2'b11;
        out_ready   = 1'b1;
        prev_gs     = -1;
        first       = 1'b1;
        g0          = grants_seen;
        repeat (13) begin
            step();
            if (grant != '0) begin
                if (first) check("t2_first_grant", 32'(grant), 32'(1));
                first = 1'b0;
                if (prev_gs >= 0) check("t2_grant_period", 32'(step_no - prev_gs), 32'(3));
                prev_gs = step_no;
            end
        end
        check("t2_grant_count", 32'(grants_seen - g0 >= 4), 32'(1));
        src_mode = 2;
        wait_req_clear(20, "t2");
        drain(200, "t2");

        // Fill to full with the consumer stalled, then release.
        src_mode    = 0;
        src_data[0] = 8'h3C;
        src_data[1] = 8'hC3;
        req         = 2'b11;
        out_ready   = 1'b0;
        n = 0;
        while (!fifo_isFull && n < 300) begin
            step();
            n++;
        end
        check("t3_fill", 32'(fifo_isFull), 32'(1));
        check("t6_valid", 32'(out_valid), 32'(1));
        held = out_data;
        g0   = grants_seen;
        d0   = drops_exp;
        repeat (20) step();
        check("t6_out_data_hold", 32'(out_data), 32'(held));
        check("t3_still_full", 32'(fifo_isFull), 32'(1));
`ifdef SAMPLE_FIFO_CTRL_DROP_EN
        check("t3_drops_per_grant", 32'(drops_exp - d0), 32'(grants_seen - g0));
        check("t3_drop_active", 32'(grants_seen - g0 > 0), 32'(1));
        check("t3_drop_count", 32'(drop_count), 32'(drops_exp));
`else
        check("t3_no_grant_when_full", 32'(grants_seen - g0), 32'(0));
`endif
        out_ready = 1'b1;
        run_until_grant(30, "t3_resume");
        src_mode = 2;
        wait_req_clear(40, "t3");
        drain(400, "t3");

        // Reset while a write strobe is in flight.
        src_data[0] = 8'h5A;
        req         = 2'b01;
        out_ready   = 1'b0;
        n = 0;
        while (!fifo_write_en && n < 10) begin
            step();
            n++;
        end
        check("t5w_strobe_reached", 32'(fifo_write_en), 32'(1));
        apply_reset("t5w");
        g0 = grants_seen;
        repeat (3) step();
        check("t5w_no_grant", 32'(grants_seen - g0), 32'(0));
        check("t5w_fifo_empty", 32'(fifo_isEmpty), 32'(1));

        // Reset while a drained sample waits for the consumer.
        src_data[0] = 8'hE7;
        req         = 2'b01;
        out_ready   = 1'b0;
        n = 0;
        while (!out_valid && n < 30) begin
            step();
            n++;
        end
        check("t5r_valid_reached", 32'(out_valid), 32'(1));
        apply_reset("t5r");
        repeat (3) step();
        check("t5r_fifo_empty", 32'(fifo_isEmpty), 32'(1));
        check("t5r_out_valid", 32'(out_valid), 32'(0));

        // Concurrent random traffic: order and count preserved over 100 samples.
        src_mode   = 1;
        raise_en   = 1'b1;
        ready_rand = 1'b1;
        base       = n_popped;
        n = 0;
        while (n_popped - base < 100 && n < 4000) begin
            step();
            n++;
        end
        check("t4_samples", 32'(n_popped - base >= 100), 32'(1));
        raise_en   = 1'b0;
        src_mode   = 2;
        ready_rand = 1'b0;
        out_ready  = 1'b1;
        wait_req_clear(100, "t4");
        drain(400, "t4");
        check("t4_fifo_empty", 32'(fifo_isEmpty), 32'(1));
`ifdef SAMPLE_FIFO_CTRL_DROP_EN
        check("t4_drop_count", 32'(drop_count), 32'(drops_exp));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
